// File: rtl/apb_requester_pkg.sv
// Shared types and constants for the APB4 requester.
package apb_requester_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic [2:0] PROT_NORMAL = 3'b000;
    localparam logic [2:0] PROT_PRIV   = 3'b001;

endpackage

// File: rtl/apb_requester.sv
// APB4 requester: takes one command on a valid/ready port, runs a single
// SETUP/ACCESS transfer, and returns read data / error status on a
// valid/ready response port.
// Optional ACCESS watchdog: define APB_REQUESTER_TIMEOUT_EN.
//
//   state  | meaning
//   IDLE   | ready for a command; bus attributes keep their last value
//   SETUP  | PSEL=1, PENABLE=0 for exactly one cycle
//   ACCESS | PSEL=1, PENABLE=1 until PREADY (or watchdog expiry)
//   RESP   | response held on rsp_* until rsp_ready
module apb_requester
    import apb_requester_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic                cmd_write,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    input  logic [2:0]          cmd_prot,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    output logic [2:0]          PPROT,
    input  logic                PREADY,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PSLVERR
);

    localparam int STRB_W = DATA_W / 8;

    state_e              state_q, state_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic [2:0]          pprot_q, pprot_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

`ifdef APB_REQUESTER_TIMEOUT_EN
    // Down-counter loaded on ACCESS entry; zero marks the last allowed ACCESS cycle.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rsp_timeout_q, rsp_timeout_d;
`else
    logic                unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // Next-state and next-output computation for the transfer FSM.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        pprot_d     = pprot_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_REQUESTER_TIMEOUT_EN
        cnt_d         = cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    pstrb_d   = cmd_write ? cmd_strb : '0;
                    pprot_d   = cmd_prot;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef APB_REQUESTER_TIMEOUT_EN
                cnt_d     = CNT_LOAD;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
`ifdef APB_REQUESTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset clears everything, aborting any transfer.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pprot_q     <= PROT_NORMAL;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_REQUESTER_TIMEOUT_EN
            cnt_q         <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            pprot_q     <= pprot_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_REQUESTER_TIMEOUT_EN
            cnt_q         <= cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    assign cmd_ready = (state_q == IDLE) && !PRESET;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign PPROT     = pprot_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
`ifdef APB_REQUESTER_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester. Watchdog cases need APB_REQUESTER_TIMEOUT_EN.
module tb_apb_requester;
    import apb_requester_pkg::*;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;

    int n_cmp = 0;
    int n_bad = 0;

    apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [3:0] strb, input logic [2:0] prot);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_write = wr;
        cmd_wdata = wd;
        cmd_strb  = strb;
        cmd_prot  = prot;
    endtask

    // Full transfer with PREADY high from the start; checks bus attributes and response.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        input logic [3:0] strb, input logic [2:0] prot,
                        input logic [31:0] rd, input logic err);
        int lat;
        offer(addr, wr, wd, strb, prot);
        #1 chk("xfer_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        PREADY  = 1'b1;
        PRDATA  = rd;
        PSLVERR = err;
        chk("xfer_paddr", PADDR, addr);
        chk("xfer_pwrite", PWRITE, wr);
        chk("xfer_pstrb", PSTRB, wr ? strb : 4'h0);
        chk("xfer_pprot", PPROT, prot);
        lat = 1;
        for (int i = 0; i < 8 && !rsp_valid; i++) begin
            tick();
            lat++;
        end
        chk("xfer_rsp_valid", rsp_valid, 1);
        chk("xfer_latency", lat, 3);
        chk("xfer_rdata", rsp_rdata, wr ? 32'h0 : rd);
        chk("xfer_err", rsp_err, err);
        chk("xfer_timeout", rsp_timeout, 0);
        PREADY = 1'b0;
        PSLVERR = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("xfer_rsp_drop", rsp_valid, 0);
    endtask

    initial begin
        PRESET = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
        cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
        PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        tick();
        tick();
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        PRESET = 1'b0;
        #1 chk("rel_cmd_ready", cmd_ready, 1);

        // 1: write, PREADY high on first ACCESS cycle
        offer(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, PROT_NORMAL);
        PREADY = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("t1_setup_psel", PSEL, 1);
        chk("t1_setup_penable", PENABLE, 0);
        chk("t1_pwdata", PWDATA, 32'hDEADBEEF);
        chk("t1_pstrb", PSTRB, 4'hF);
        chk("t1_cmd_ready", cmd_ready, 0);
        tick();
        chk("t1_access_psel", PSEL, 1);
        chk("t1_access_penable", PENABLE, 1);
        chk("t1_access_rsp", rsp_valid, 0);
        tick();
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_psel_drop", PSEL, 0);
        chk("t1_penable_drop", PENABLE, 0);
        chk("t1_rsp_err", rsp_err, 0);
        chk("t1_rsp_rdata", rsp_rdata, 0);
        PREADY = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t1_idle_rsp", rsp_valid, 0);
        chk("t1_idle_paddr_kept", PADDR, 32'h10);
        chk("t1_idle_cmd_ready", cmd_ready, 1);

        // 2: read with three wait states
        offer(32'h24, 1'b0, 32'hFFFFFFFF, 4'hF, PROT_NORMAL);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_psel", PSEL, 1);
            chk("t2_penable", PENABLE, (i > 0) ? 1 : 0);
            chk("t2_paddr", PADDR, 32'h24);
            chk("t2_pstrb", PSTRB, 0);
            chk("t2_no_rsp", rsp_valid, 0);
            if (i == 4) begin
                PREADY = 1'b1;
                PRDATA = 32'h12345678;
            end
            tick();
        end
        PREADY = 1'b0;
        PRDATA = 32'h0;
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rsp_rdata", rsp_rdata, 32'h12345678);
        chk("t2_rsp_err", rsp_err, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 3: read error with stalled response consumer
        offer(32'h30, 1'b0, 32'h0, 4'h0, PROT_PRIV);
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hCAFE0001;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
        offer(32'h99, 1'b1, 32'h1, 4'h1, PROT_NORMAL);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_rsp_valid", rsp_valid, 1);
            chk("t3_rsp_err", rsp_err, 1);
            chk("t3_rsp_rdata", rsp_rdata, 32'hCAFE0001);
            chk("t3_cmd_ready", cmd_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1 chk("t3_hs_cmd_ready", cmd_ready, 0);
        tick();
        rsp_ready = 1'b0;
        chk("t3_after_rsp", rsp_valid, 0);
        chk("t3_after_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b0;
        tick();
        chk("t3_not_taken", PSEL, 0);

        // 4: reset in the second ACCESS cycle
        offer(32'h40, 1'b1, 32'h55AA55AA, 4'hF, PROT_PRIV);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("t4_access2_penable", PENABLE, 1);
        PRESET = 1'b1;
        #1 chk("t4_rst_cmd_ready", cmd_ready, 0);
        tick();
        chk("t4_psel", PSEL, 0);
        chk("t4_penable", PENABLE, 0);
        chk("t4_rsp_valid", rsp_valid, 0);
        chk("t4_paddr", PADDR, 0);
        chk("t4_pwdata", PWDATA, 0);
        chk("t4_pprot", PPROT, 0);
        chk("t4_pwrite", PWRITE, 0);
        PRESET = 1'b0;
        tick();
        tick();
        chk("t4_no_rsp", rsp_valid, 0);
        xfer(32'h44, 1'b0, 32'h0, 4'hF, PROT_NORMAL, 32'h0BADF00D, 1'b0);

        // Extra patterns: partial strobe privileged write, error write
        xfer(32'h1000_0008, 1'b1, 32'hA5A5_0F0F, 4'h5, PROT_PRIV, 32'hFFFF_FFFF, 1'b0);
        xfer(32'h8000_0000, 1'b1, 32'h0000_0001, 4'h1, PROT_NORMAL, 32'h1234_0000, 1'b1);

`ifdef APB_REQUESTER_TIMEOUT_EN
        // 5: watchdog abort after 4 ACCESS cycles
        offer(32'h50, 1'b0, 32'h0, 4'h0, PROT_NORMAL);
        PRDATA = 32'h77777777;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t5_penable", PENABLE, 1);
            chk("t5_no_rsp", rsp_valid, 0);
            tick();
        end
        chk("t5_rsp_valid", rsp_valid, 1);
        chk("t5_rsp_err", rsp_err, 1);
        chk("t5_rsp_timeout", rsp_timeout, 1);
        chk("t5_rsp_rdata", rsp_rdata, 0);
        chk("t5_psel", PSEL, 0);
        chk("t5_penable_drop", PENABLE, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 6: PREADY on the 4th ACCESS cycle completes normally
        offer(32'h54, 1'b0, 32'h0, 4'h0, PROT_NORMAL);
        PRDATA = 32'h600DF00D;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        PREADY = 1'b1;
        chk("t6_still_access", PENABLE, 1);
        tick();
        PREADY = 1'b0;
        chk("t6_rsp_valid", rsp_valid, 1);
        chk("t6_rsp_timeout", rsp_timeout, 0);
        chk("t6_rsp_err", rsp_err, 0);
        chk("t6_rsp_rdata", rsp_rdata, 32'h600DF00D);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
